rf_write_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two requesters.
- Requester 1: the pipeline writeback stage. Always served, cannot be back-pressured except through a stall.
- Requester 2: a long-latency unit (mult/div), served over a valid/ready handshake.
- Holds a per-register busy scoreboard for outstanding long-unit ops and reports RAW/WAW hazards to the decode stage. Forces a one-cycle pipeline stall when the long unit starves.

---
 rtl/rf_write_arbiter_pkg.sv | 21 ++
 rtl/rf_write_arbiter_if.sv | 63 ++++++
 rtl/rf_write_arbiter_scoreboard.sv | 53 +++++
 rtl/rf_write_arbiter.sv | 132 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int unsigned RfWordLen = 32;
  localparam int unsigned RfAddrLen = 5;
  localparam int unsigned RfSize    = 32;
  localparam int unsigned RfMaxWait = 4;

  // Write-port arbitration states; encodings are fixed so traces match older tooling.
  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbWait  = 2'd1,
    ArbForce = 2'd2
  } arb_state_e;

  // Width of the blocked-cycle counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_wait);
    return (max_wait > 2) ? $clog2(max_wait) : 1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Request/grant bundle between the pipeline, long unit, decode and the arbiter.
// Bypass signals exist only when RF_ARB_BYPASS_EN is defined.
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned WORD_LEN = RfWordLen,
  parameter int unsigned ADDR_LEN = RfAddrLen
);

  // Pipeline writeback
  logic                wb_en;
  logic [ADDR_LEN-1:0] wb_dest;
  logic [WORD_LEN-1:0] wb_val;
  // Long-unit result handshake
  logic                lu_valid;
  logic [ADDR_LEN-1:0] lu_dest;
  logic [WORD_LEN-1:0] lu_val;
  logic                lu_ready;
  // Long-op issue and decode queries
  logic                iss_en;
  logic [ADDR_LEN-1:0] iss_dest;
  logic [ADDR_LEN-1:0] q_src1;
  logic [ADDR_LEN-1:0] q_src2;
  logic [ADDR_LEN-1:0] q_dest;
  logic                hazard;
  logic                stall_pipe;
  // Register-file write port
  logic                rf_writeEn;
  logic [ADDR_LEN-1:0] rf_dest;
  logic [WORD_LEN-1:0] rf_writeVal;
`ifdef RF_ARB_BYPASS_EN
  logic                byp1;
  logic                byp2;
  logic [WORD_LEN-1:0] byp_val;
`endif

  // Arbiter side
  modport slave (
    input  wb_en, wb_dest, wb_val,
    input  lu_valid, lu_dest, lu_val,
    output lu_ready,
    input  iss_en, iss_dest, q_src1, q_src2, q_dest,
    output hazard, stall_pipe,
`ifdef RF_ARB_BYPASS_EN
    output byp1, byp2, byp_val,
`endif
    output rf_writeEn, rf_dest, rf_writeVal
  );

  // Environment side
  modport master (
    output wb_en, wb_dest, wb_val,
    output lu_valid, lu_dest, lu_val,
    input  lu_ready,
    output iss_en, iss_dest, q_src1, q_src2, q_dest,
    input  hazard, stall_pipe,
`ifdef RF_ARB_BYPASS_EN
    input  byp1, byp2, byp_val,
`endif
    input  rf_writeEn, rf_dest, rf_writeVal
  );

endinterface

// File: rtl/rf_write_arbiter_scoreboard.sv
// Busy scoreboard for registers with an outstanding long-unit result.
// Issue sets, granted long-unit write clears; set wins on a same-edge collision.
module rf_write_arbiter_scoreboard #(
  parameter int unsigned ADDR_LEN  = 5,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en_i,
  input  logic [ADDR_LEN-1:0] set_addr_i,
  input  logic                clr_en_i,
  input  logic [ADDR_LEN-1:0] clr_addr_i,
  input  logic [ADDR_LEN-1:0] q_src1_i,
  input  logic [ADDR_LEN-1:0] q_src2_i,
  input  logic [ADDR_LEN-1:0] q_dest_i,
  output logic                busy_src1_o,
  output logic                busy_src2_o,
  output logic                busy_dest_o
);

  logic [REG_COUNT-1:0] busy_q, busy_d;

  // Addresses beyond the architectural file are never busy.
  function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
    return 32'(a) < REG_COUNT;
  endfunction

  // Next busy vector: clear first so a simultaneous set takes priority; r0 stays free.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i && in_range(clr_addr_i)) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (set_en_i && (set_addr_i != '0) && in_range(set_addr_i)) begin
      busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_src1_o = in_range(q_src1_i) ? busy_q[q_src1_i] : 1'b0;
  assign busy_src2_o = in_range(q_src2_i) ? busy_q[q_src2_i] : 1'b0;
  assign busy_dest_o = in_range(q_dest_i) ? busy_q[q_dest_i] : 1'b0;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, the long
// unit waits up to MAX_WAIT blocked cycles before a one-cycle forced stall.
// Optional operand bypass from the granted long-unit write: RF_ARB_BYPASS_EN.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned WORD_LEN  = RfWordLen,
  parameter int unsigned ADDR_LEN  = RfAddrLen,
  parameter int unsigned REG_COUNT = RfSize,
  parameter int unsigned MAX_WAIT  = RfMaxWait  // must be at least 2
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);

  localparam int unsigned     CntW    = cnt_width(MAX_WAIT);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  arb_state_e          state_q;
  logic [CntW-1:0]     cnt_q;
  logic                stall_q;
  logic                grant_wb, grant_lu;
  logic [ADDR_LEN-1:0] wr_dest;
  logic [WORD_LEN-1:0] wr_val;
  logic                busy_src1, busy_src2, busy_dest;

  // Arbitration FSM; stall is registered so it has no combinational input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ArbIdle;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      unique case (state_q)
        ArbIdle: begin
          if (bus.wb_en && bus.lu_valid) begin
            state_q <= ArbWait;
            cnt_q   <= CntOne;
          end
        end
        ArbWait: begin
          if (!bus.wb_en) begin
            state_q <= ArbIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= ArbForce;
            stall_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        ArbForce: begin
          state_q <= ArbIdle;
          cnt_q   <= '0;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= ArbIdle;
          cnt_q   <= '0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  // Grant decision: pipeline wins except in the forced cycle; nothing during reset.
  always_comb begin
    grant_wb = 1'b0;
    grant_lu = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ArbIdle, ArbWait: begin
          if (bus.wb_en) begin
            grant_wb = 1'b1;
          end else begin
            grant_lu = bus.lu_valid;
          end
        end
        ArbForce: grant_lu = bus.lu_valid;
        default:  ;
      endcase
    end
  end

  // Write-port mux; the register file samples on negedge within the grant cycle.
  always_comb begin
    wr_dest = grant_lu ? bus.lu_dest : bus.wb_dest;
    wr_val  = grant_lu ? bus.lu_val  : bus.wb_val;
  end

  // r0 writes complete the handshake but never reach the file.
  assign bus.rf_writeEn  = (grant_wb || grant_lu) && (wr_dest != '0);
  assign bus.rf_dest     = wr_dest;
  assign bus.rf_writeVal = wr_val;
  assign bus.lu_ready    = grant_lu;
  assign bus.stall_pipe  = stall_q && !rst;

  rf_write_arbiter_scoreboard #(
    .ADDR_LEN (ADDR_LEN),
    .REG_COUNT(REG_COUNT)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (bus.iss_en),
    .set_addr_i (bus.iss_dest),
    .clr_en_i   (grant_lu),
    .clr_addr_i (bus.lu_dest),
    .q_src1_i   (bus.q_src1),
    .q_src2_i   (bus.q_src2),
    .q_dest_i   (bus.q_dest),
    .busy_src1_o(busy_src1),
    .busy_src2_o(busy_src2),
    .busy_dest_o(busy_dest)
  );

`ifdef RF_ARB_BYPASS_EN
  logic byp1, byp2;

  // A source being written by the long unit this cycle can be forwarded.
  assign byp1        = grant_lu && (bus.q_src1 != '0) && (bus.lu_dest == bus.q_src1);
  assign byp2        = grant_lu && (bus.q_src2 != '0) && (bus.lu_dest == bus.q_src2);
  assign bus.byp1    = byp1;
  assign bus.byp2    = byp2;
  assign bus.byp_val = (byp1 || byp2) ? bus.lu_val : '0;
  assign bus.hazard  = !rst && ((busy_src1 && !byp1) || (busy_src2 && !byp2) || busy_dest);
`else
  assign bus.hazard  = !rst && (busy_src1 || busy_src2 || busy_dest);
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed steps followed by random
// traffic, checked against a behavioural model of the arbitration rules.
module tb_rf_write_arbiter;

  localparam int unsigned WL = 32;
  localparam int unsigned AL = 5;
  localparam int unsigned RC = 32;
  localparam int unsigned MW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Model state: busy flags and consecutive cycles the long unit has been refused.
  bit   busy_m [RC];
  int   blocked = 0;
  bit   e_force, e_glu, e_gwb;
  logic [AL-1:0] last_iss = '0;

  always #5 clk = ~clk;

  rf_write_arbiter_if #(.WORD_LEN(WL), .ADDR_LEN(AL)) bus ();

  rf_write_arbiter #(
    .WORD_LEN (WL),
    .ADDR_LEN (AL),
    .REG_COUNT(RC),
    .MAX_WAIT (MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model for the inputs currently driven.
  task automatic settle_check();
    logic          e_we, e_haz, b1, b2;
    logic [AL-1:0] e_dest;
    logic [WL-1:0] e_val;
    #3;
    if (rst) begin
      e_force = 1'b0;
      e_glu   = 1'b0;
      e_gwb   = 1'b0;
    end else begin
      // Long unit refused MW times in a row gets the port no matter what.
      e_force = (blocked >= MW);
      e_glu   = e_force ? bus.lu_valid : (!bus.wb_en && bus.lu_valid);
      e_gwb   = !e_force && bus.wb_en;
    end
    e_dest = e_glu ? bus.lu_dest : bus.wb_dest;
    e_val  = e_glu ? bus.lu_val : bus.wb_val;
    e_we   = (e_glu || e_gwb) && (e_dest != 0);
`ifdef RF_ARB_BYPASS_EN
    b1 = e_glu && bus.q_src1 != 0 && bus.q_src1 == bus.lu_dest;
    b2 = e_glu && bus.q_src2 != 0 && bus.q_src2 == bus.lu_dest;
`else
    b1 = 1'b0;
    b2 = 1'b0;
`endif
    e_haz = !rst && ((busy_m[bus.q_src1] && !b1) || (busy_m[bus.q_src2] && !b2)
                     || busy_m[bus.q_dest]);
    check("lu_ready", 64'(bus.lu_ready), 64'(e_glu));
    check("stall_pipe", 64'(bus.stall_pipe), 64'(e_force));
    check("rf_writeEn", 64'(bus.rf_writeEn), 64'(e_we));
    check("hazard", 64'(bus.hazard), 64'(e_haz));
    if (e_we) begin
      check("rf_dest", 64'(bus.rf_dest), 64'(e_dest));
      check("rf_writeVal", 64'(bus.rf_writeVal), 64'(e_val));
    end
`ifdef RF_ARB_BYPASS_EN
    check("byp1", 64'(bus.byp1), 64'(b1));
    check("byp2", 64'(bus.byp2), 64'(b2));
    if (b1 || b2) check("byp_val", 64'(bus.byp_val), 64'(bus.lu_val));
`endif
  endtask

  // Clock edge and model update from the decisions of the cycle just checked.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      blocked = 0;
    end else begin
      if (e_glu) busy_m[bus.lu_dest] = 1'b0;
      if (bus.iss_en && bus.iss_dest != 0) busy_m[bus.iss_dest] = 1'b1;
      if (e_force) blocked = 0;
      else if (e_gwb && bus.lu_valid) blocked++;
      else blocked = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_en    = 1'b0;  bus.wb_dest  = '0; bus.wb_val = '0;
    bus.lu_valid = 1'b0;  bus.lu_dest  = '0; bus.lu_val = '0;
    bus.iss_en   = 1'b0;  bus.iss_dest = '0;
    bus.q_src1   = '0;    bus.q_src2   = '0; bus.q_dest = '0;
  endtask

  initial begin
    // Reset with every input high
    rst = 1'b1;
    bus.wb_en = 1'b1; bus.wb_dest = '1; bus.wb_val = '1;
    bus.lu_valid = 1'b1; bus.lu_dest = '1; bus.lu_val = '1;
    bus.iss_en = 1'b1; bus.iss_dest = '1;
    bus.q_src1 = '1; bus.q_src2 = '1; bus.q_dest = '1;
    repeat (2) begin
      settle_check();
      check("rst_writeEn", 64'(bus.rf_writeEn), 64'd0);
      check("rst_hazard", 64'(bus.hazard), 64'd0);
      advance();
    end
    rst = 1'b0;
    idle_inputs();

    // Scoreboard empty after reset
    for (int r = 0; r < int'(RC); r++) begin
      bus.q_src1 = AL'(r); bus.q_src2 = AL'(r); bus.q_dest = AL'(r);
      @(negedge clk);
      check("post_rst_busy", 64'(bus.hazard), 64'd0);
    end
    @(posedge clk); #1;
    idle_inputs();

    // Idle port: long unit granted in the same cycle
    bus.lu_valid = 1'b1; bus.lu_dest = 5'd7; bus.lu_val = 32'hDEADBEEF;
    settle_check();
    check("lu_direct_ready", 64'(bus.lu_ready), 64'd1);
    check("lu_direct_dest", 64'(bus.rf_dest), 64'd7);
    check("lu_direct_val", 64'(bus.rf_writeVal), 64'hDEADBEEF);
    advance();

    // Starvation: four pipeline cycles, forced stall, then the held WB write
    bus.wb_en = 1'b1; bus.wb_dest = 5'd3; bus.wb_val = 32'h1111_1111;
    bus.lu_valid = 1'b1; bus.lu_dest = 5'd8; bus.lu_val = 32'h2222_2222;
    for (int c = 0; c < int'(MW); c++) begin
      settle_check();
      check("starve_ready", 64'(bus.lu_ready), 64'd0);
      check("starve_stall", 64'(bus.stall_pipe), 64'd0);
      check("starve_val", 64'(bus.rf_writeVal), 64'h1111_1111);
      advance();
    end
    settle_check();
    check("force_stall", 64'(bus.stall_pipe), 64'd1);
    check("force_ready", 64'(bus.lu_ready), 64'd1);
    check("force_dest", 64'(bus.rf_dest), 64'd8);
    advance();
    bus.lu_valid = 1'b0;
    settle_check();
    check("after_force_stall", 64'(bus.stall_pipe), 64'd0);
    check("after_force_val", 64'(bus.rf_writeVal), 64'h1111_1111);
    check("after_force_we", 64'(bus.rf_writeEn), 64'd1);
    advance();
    idle_inputs();

    // RAW hazard on r9 until the long-unit write lands
    bus.iss_en = 1'b1; bus.iss_dest = 5'd9; bus.q_src2 = 5'd9;
    settle_check();
    check("iss9_same_cycle", 64'(bus.hazard), 64'd0);
    advance();
    bus.iss_en = 1'b0; bus.wb_en = 1'b1; bus.wb_dest = 5'd1;
    settle_check();
    check("iss9_busy", 64'(bus.hazard), 64'd1);
    advance();
    bus.wb_en = 1'b0; bus.lu_valid = 1'b1; bus.lu_dest = 5'd9; bus.lu_val = 32'h0000_0ABC;
    settle_check();
`ifdef RF_ARB_BYPASS_EN
    check("iss9_grant_byp", 64'(bus.hazard), 64'd0);
`else
    check("iss9_grant", 64'(bus.hazard), 64'd1);
`endif
    advance();
    bus.lu_valid = 1'b0;
    settle_check();
    check("iss9_cleared", 64'(bus.hazard), 64'd0);
    advance();
    idle_inputs();

    // Same-edge set and clear of r5: set wins; issue to r0 changes nothing
    bus.iss_en = 1'b1; bus.iss_dest = 5'd5;
    settle_check(); advance();
    bus.lu_valid = 1'b1; bus.lu_dest = 5'd5; bus.lu_val = 32'h5;
    settle_check(); advance();
    idle_inputs(); bus.q_dest = 5'd5;
    settle_check();
    check("set_wins", 64'(bus.hazard), 64'd1);
    advance();
    bus.lu_valid = 1'b1; bus.lu_dest = 5'd5;
    settle_check(); advance();
    bus.lu_valid = 1'b0; bus.iss_en = 1'b1; bus.iss_dest = 5'd0;
    settle_check(); advance();
    bus.iss_en = 1'b0; bus.q_src1 = 5'd0;
    settle_check();
    check("r0_never_busy", 64'(bus.hazard), 64'd0);
    advance();
    idle_inputs();

    // Writes to r0 handshake without enabling the file
    bus.lu_valid = 1'b1; bus.lu_dest = 5'd0; bus.lu_val = 32'h55;
    settle_check();
    check("r0_lu_ready", 64'(bus.lu_ready), 64'd1);
    check("r0_lu_we", 64'(bus.rf_writeEn), 64'd0);
    advance();
    idle_inputs();
    bus.wb_en = 1'b1; bus.wb_dest = 5'd0; bus.wb_val = 32'h66;
    settle_check();
    check("r0_wb_we", 64'(bus.rf_writeEn), 64'd0);
    advance();
    idle_inputs();

`ifdef RF_ARB_BYPASS_EN
    // Bypass of r3 to source 1
    bus.iss_en = 1'b1; bus.iss_dest = 5'd3;
    settle_check(); advance();
    bus.iss_en = 1'b0; bus.lu_valid = 1'b1; bus.lu_dest = 5'd3; bus.lu_val = 32'h3333;
    bus.q_src1 = 5'd3;
    settle_check();
    check("byp1_on", 64'(bus.byp1), 64'd1);
    check("byp1_val", 64'(bus.byp_val), 64'h3333);
    check("byp1_no_hazard", 64'(bus.hazard), 64'd0);
    advance();
    idle_inputs();
`endif

    // Reset in the middle of a wait discards the pending grant
    bus.wb_en = 1'b1; bus.wb_dest = 5'd2; bus.lu_valid = 1'b1; bus.lu_dest = 5'd12;
    repeat (2) begin settle_check(); advance(); end
    rst = 1'b1;
    settle_check(); advance();
    rst = 1'b0; bus.lu_valid = 1'b0;
    settle_check(); advance();
    bus.wb_en = 1'b0; bus.lu_valid = 1'b1;
    settle_check();
    check("post_rst_idle", 64'(bus.lu_ready), 64'd1);
    advance();
    idle_inputs();

    // Random traffic obeying the long-unit hold rule and the issue rule
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(299) == 0);
      bus.wb_en   = ($urandom_range(2) != 0);
      bus.wb_dest = AL'($urandom);
      bus.wb_val  = $urandom;
      if (blocked == 0) begin
        bus.lu_valid = $urandom_range(1) == 1;
        bus.lu_dest  = ($urandom_range(1) == 1) ? last_iss : AL'($urandom);
        bus.lu_val   = $urandom;
      end
      bus.iss_en   = ($urandom_range(3) == 0);
      bus.iss_dest = AL'($urandom);
      if (busy_m[bus.iss_dest]) bus.iss_dest = '0;
      if (bus.iss_en && bus.iss_dest != 0) last_iss = bus.iss_dest;
      bus.q_src1 = ($urandom_range(1) == 1) ? last_iss : AL'($urandom);
      bus.q_src2 = AL'($urandom);
      bus.q_dest = AL'($urandom);
      settle_check();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
